// File: rtl/free_play_pkg.sv
// free_play_pkg: note table, half-period helpers and code constants
// shared by the free-play voice.
package free_play_pkg;

  localparam int unsigned CODE_REST = 0;
  localparam int unsigned CODE_MAX  = 7;

  localparam logic [6:0][31:0] NOTE_MHZ = {
    32'd493883, 32'd440000, 32'd391995, 32'd349228,
    32'd329628, 32'd293665, 32'd261626
  };

  typedef logic [7:0][31:0] hp_tab_t;

  function automatic logic [31:0] HALF_PERIOD(
    input int unsigned     code,
    input longint unsigned clk_hz
  );
    logic [63:0] num;
    if (code == CODE_REST || code > CODE_MAX)
      return 32'd0;
    num = clk_hz * 64'd500;
    return 32'(num / 64'(NOTE_MHZ[code-1]));
  endfunction

  function automatic hp_tab_t half_table(
    input longint unsigned clk_hz
  );
    hp_tab_t t;
    for (int c = 0; c < 8; c++)
      t[c] = HALF_PERIOD(c, clk_hz);
    return t;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus stable-count debouncer
// for one raw key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
)(
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      sync <= {sync[0], key};
      if (sync[1] != state) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          state <= ~state;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/free_play_engine.sv
// free_play_engine: last-pressed-priority key voice with square-wave out.
// Optional release tail enabled by FREE_PLAY_SUSTAIN_EN.
module free_play_engine
  import free_play_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int          NUM_KEYS        = 8,
  parameter int          MAP_W           = 3,
  parameter int          DEBOUNCE_CYCLES = 2_000_000,
  parameter int          SUSTAIN_CYCLES  = 25_000_000
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_KEYS-1:0]       keys,
  input  logic [NUM_KEYS*MAP_W-1:0] key_map,
  input  logic [1:0]                octave,
  output logic                      speaker,
  output logic                      note_active,
  output logic [MAP_W-1:0]          note_code
);

  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam hp_tab_t HP_TAB = half_table(64'(CLK_HZ));

  logic [NUM_KEYS-1:0] deb, deb_q, rise;
  logic [IW-1:0]       cur, cur_nxt, rise_idx, held_idx;
  logic                cur_vld, cur_vld_nxt;
  logic [MAP_W-1:0]    map_code, sel_code, code_nxt;
  logic [31:0]         hp, cnt;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (keys[i]),
      .state (deb[i])
    );
  end

  always_comb begin
    rise     = deb & ~deb_q;
    rise_idx = '0;
    held_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = IW'(i);
      if (deb[i])  held_idx = IW'(i);
    end
    cur_nxt     = cur;
    cur_vld_nxt = cur_vld;
    if (|rise) begin
      cur_nxt     = rise_idx;
      cur_vld_nxt = 1'b1;
    end else if (cur_vld && deb[cur]) begin
      cur_vld_nxt = 1'b1;
    end else if (|deb) begin
      cur_nxt     = held_idx;
      cur_vld_nxt = 1'b1;
    end else begin
      cur_vld_nxt = 1'b0;
    end
    map_code = key_map[int'(cur_nxt)*MAP_W +: MAP_W];
    sel_code = '0;
    if (cur_vld_nxt && 32'(map_code) <= CODE_MAX)
      sel_code = map_code;
  end

`ifdef FREE_PLAY_SUSTAIN_EN
  localparam int SW = $clog2(SUSTAIN_CYCLES + 1);

  logic          sus;
  logic [SW-1:0] sus_cnt;

  // Tail replays the last sounding code until the count runs out
  always_comb begin
    code_nxt = '0;
    if (!enable)
      code_nxt = '0;
    else if (cur_vld_nxt)
      code_nxt = sel_code;
    else if (!sus && note_code != '0)
      code_nxt = note_code;
    else if (sus && sus_cnt < SW'(SUSTAIN_CYCLES))
      code_nxt = note_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sus     <= 1'b0;
      sus_cnt <= '0;
    end else if (!enable || cur_vld_nxt) begin
      sus     <= 1'b0;
      sus_cnt <= '0;
    end else if (!sus) begin
      if (note_code != '0) begin
        sus     <= 1'b1;
        sus_cnt <= SW'(1);
      end
    end else if (sus_cnt < SW'(SUSTAIN_CYCLES)) begin
      sus_cnt <= sus_cnt + 1'b1;
    end
  end
`else
  localparam int unused_sustain = SUSTAIN_CYCLES;

  always_comb begin
    code_nxt = '0;
    if (enable)
      code_nxt = sel_code;
  end
`endif

  assign hp = HP_TAB[note_code[2:0]] >> octave;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q       <= '0;
      cur         <= '0;
      cur_vld     <= 1'b0;
      speaker     <= 1'b0;
      note_active <= 1'b0;
      note_code   <= '0;
      cnt         <= '0;
    end else begin
      deb_q   <= deb;
      cur     <= cur_nxt;
      cur_vld <= cur_vld_nxt;
      if (code_nxt == '0) begin
        speaker     <= 1'b0;
        note_active <= 1'b0;
        note_code   <= '0;
        cnt         <= '0;
      end else if (code_nxt != note_code) begin
        note_active <= 1'b1;
        note_code   <= code_nxt;
        cnt         <= '0;
      end else if (cnt >= hp - 32'd1) begin
        speaker <= ~speaker;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_free_play_engine.sv
// tb_free_play_engine: directed scenarios for free_play_engine.
// Define FREE_PLAY_SUSTAIN_EN to add the release-tail scenario.
module tb_free_play_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  keys;
  logic [23:0] key_map;
  logic [1:0]  octave;
  logic        speaker;
  logic        note_active;
  logic [2:0]  note_code;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  free_play_engine #(
    .CLK_HZ          (1_000_000),
    .NUM_KEYS        (8),
    .MAP_W           (3),
    .DEBOUNCE_CYCLES (4),
    .SUSTAIN_CYCLES  (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .keys        (keys),
    .key_map     (key_map),
    .octave      (octave),
    .speaker     (speaker),
    .note_active (note_active),
    .note_code   (note_code)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure_half(output int n);
    logic lvl;
    lvl = speaker;
    n = 0;
    while (speaker === lvl && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; keys = '0; octave = 2'd0;
    key_map = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    cyc(3);
    checks++;
    if ({speaker, note_active, note_code} !== 5'b0) begin
      fails++;
      $display("FAIL reset_state: got %b expected 00000",
               {speaker, note_active, note_code});
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_press;
    int n;
    keys[0] = 1'b1;
    cyc(6);
    checks++;
    if (note_code !== 3'd0) begin
      fails++;
      $display("FAIL press_early: got %0d expected 0", note_code);
    end
    cyc(1);
    checks++;
    if (note_code !== 3'd1 || note_active !== 1'b1) begin
      fails++;
      $display("FAIL press_code: got %0d/%b expected 1/1",
               note_code, note_active);
    end
    measure_half(n);
    checks++;
    if (n !== 1911) begin
      fails++;
      $display("FAIL press_first_half: got %0d expected 1911", n);
    end
    measure_half(n);
    checks++;
    if (n !== 1911) begin
      fails++;
      $display("FAIL press_half: got %0d expected 1911", n);
    end
  endtask

  task automatic test_priority;
    int n;
    keys[5] = 1'b1;
    cyc(7);
    checks++;
    if (note_code !== 3'd6) begin
      fails++;
      $display("FAIL prio_new: got %0d expected 6", note_code);
    end
    measure_half(n);
    checks++;
    if (n !== 1136) begin
      fails++;
      $display("FAIL prio_half: got %0d expected 1136", n);
    end
    keys[5] = 1'b0;
    cyc(6);
    checks++;
    if (note_code !== 3'd6) begin
      fails++;
      $display("FAIL prio_hold: got %0d expected 6", note_code);
    end
    cyc(1);
    checks++;
    if (note_code !== 3'd1) begin
      fails++;
      $display("FAIL prio_fallback: got %0d expected 1", note_code);
    end
    keys[0] = 1'b0;
    cyc(7);
    checks++;
    if ({speaker, note_active, note_code} !== 5'b0) begin
      fails++;
      $display("FAIL prio_silent: got %b expected 00000",
               {speaker, note_active, note_code});
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 10; i++) begin
      keys[2] = ~keys[2];
      cyc(2);
      checks++;
      if (note_code !== 3'd0) begin
        fails++;
        $display("FAIL bounce_%0d: got %0d expected 0", i, note_code);
      end
    end
    keys[2] = 1'b1;
    cyc(6);
    checks++;
    if (note_code !== 3'd0) begin
      fails++;
      $display("FAIL bounce_early: got %0d expected 0", note_code);
    end
    cyc(1);
    checks++;
    if (note_code !== 3'd3) begin
      fails++;
      $display("FAIL bounce_stable: got %0d expected 3", note_code);
    end
    keys[2] = 1'b0;
    cyc(8);
  endtask

  task automatic test_octave;
    int n;
    keys[5] = 1'b1;
    cyc(7);
    measure_half(n);
    checks++;
    if (n !== 1136) begin
      fails++;
      $display("FAIL oct0_half: got %0d expected 1136", n);
    end
    octave = 2'd2;
    measure_half(n);
    checks++;
    if (n !== 284) begin
      fails++;
      $display("FAIL oct2_half: got %0d expected 284", n);
    end
    octave = 2'd0;
    measure_half(n);
    cyc(500);
    octave = 2'd2;
    measure_half(n);
    checks++;
    if (n !== 1) begin
      fails++;
      $display("FAIL oct_wrap: got %0d expected 1", n);
    end
    octave = 2'd0;
    keys[5] = 1'b0;
    keys[7] = 1'b1;
    cyc(10);
    checks++;
    if (note_active !== 1'b0 || note_code !== 3'd0) begin
      fails++;
      $display("FAIL rest_key: got %b/%0d expected 0/0",
               note_active, note_code);
    end
    keys[7] = 1'b0;
    cyc(8);
  endtask

  task automatic test_enable;
    int n;
    keys[0] = 1'b1;
    cyc(107);
    enable = 1'b0;
    cyc(1);
    checks++;
    if ({speaker, note_active, note_code} !== 5'b0) begin
      fails++;
      $display("FAIL enable_off: got %b expected 00000",
               {speaker, note_active, note_code});
    end
    cyc(5);
    enable = 1'b1;
    cyc(1);
    checks++;
    if (note_code !== 3'd1 || note_active !== 1'b1) begin
      fails++;
      $display("FAIL enable_on: got %0d/%b expected 1/1",
               note_code, note_active);
    end
    measure_half(n);
    checks++;
    if (n !== 1911) begin
      fails++;
      $display("FAIL enable_half: got %0d expected 1911", n);
    end
  endtask

  task automatic test_reset_mid;
    cyc(100);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({speaker, note_active, note_code} !== 5'b0) begin
      fails++;
      $display("FAIL reset_async: got %b expected 00000",
               {speaker, note_active, note_code});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6);
    checks++;
    if (note_code !== 3'd0) begin
      fails++;
      $display("FAIL reset_redeb_early: got %0d expected 0", note_code);
    end
    cyc(1);
    checks++;
    if (note_code !== 3'd1) begin
      fails++;
      $display("FAIL reset_redeb: got %0d expected 1", note_code);
    end
  endtask

`ifdef FREE_PLAY_SUSTAIN_EN
  task automatic test_sustain;
    keys[0] = 1'b0;
    cyc(106);
    checks++;
    if (note_code !== 3'd1) begin
      fails++;
      $display("FAIL sus_tail: got %0d expected 1", note_code);
    end
    cyc(1);
    checks++;
    if (note_code !== 3'd0) begin
      fails++;
      $display("FAIL sus_end: got %0d expected 0", note_code);
    end
    keys[0] = 1'b1;
    cyc(20);
    keys[0] = 1'b0;
    cyc(50);
    keys[1] = 1'b1;
    cyc(6);
    checks++;
    if (note_code !== 3'd1) begin
      fails++;
      $display("FAIL sus_mid: got %0d expected 1", note_code);
    end
    cyc(1);
    checks++;
    if (note_code !== 3'd2) begin
      fails++;
      $display("FAIL sus_takeover: got %0d expected 2", note_code);
    end
    cyc(100);
    checks++;
    if (note_code !== 3'd2) begin
      fails++;
      $display("FAIL sus_after: got %0d expected 2", note_code);
    end
    keys[1] = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_press;
    test_priority;
    test_bounce;
    test_octave;
    test_enable;
    test_reset_mid;
`ifdef FREE_PLAY_SUSTAIN_EN
    test_sustain;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/free_play_engine.md
# free_play_engine

Parametrised free-play voice for the piano: debounces N raw keys and selects one sounding key with last-pressed priority. The selected key is translated through a runtime key-to-note map with octave shift, and a square wave is driven on the buzzer pin. It replaces the fixed 8-key combinational map plus buzzer pair in the free mode path and sits between the switch/button inputs and `speaker`.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000 — system clock frequency.
- `NUM_KEYS`, 8 — number of key inputs.
- `MAP_W`, 3 — note-code width per key. Code 0 = rest; codes 1..7 = C4..B4.
- `DEBOUNCE_CYCLES`, 2_000_000 — stable cycles required before a key change is accepted.
- `SUSTAIN_CYCLES`, 25_000_000 — release tail length; used only with the macro.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1 — system clock.
- `rst_n` in 1 — async active-low reset.
- `enable` in 1 — mode enable. Low forces silence.
- `keys` in NUM_KEYS — raw, asynchronous, active-high keys.
- `key_map` in NUM_KEYS*MAP_W — note code for key i is slice [i*MAP_W +: MAP_W].
- `octave` in 2 — 0..3. Each step doubles the frequency.
- `speaker` out 1 — square-wave buzzer drive.
- `note_active` out 1 — high while a tone is sounding.
- `note_code` out MAP_W — code currently sounding; 0 when silent.

## Operation
- **Input sync:** 2-flop synchroniser per key.
- **Debounce:** one counter per key. When the synced input ≠ the debounced state for DEBOUNCE_CYCLES consecutive cycles, the debounced state flips. Any bounce back resets the counter.
- **Priority:**
  - A debounced rising edge makes that key current.
  - Simultaneous rising edges: lowest index wins.
  - When the current key releases and other keys are held, the lowest-index held key becomes current.
  - No key held: no current key.
- **Code:** `code` = key_map slice of the current key; 0 when there is no current key. A mapped code of 0 is treated as a rest (silent).
- **Tone:**
  - half_period = HALF_PERIOD(code, CLK_HZ) >> octave.
  - Counter runs 0..half_period-1; `speaker` toggles on wrap.
  - On a code change the counter restarts at 0 and `speaker` holds its level.
  - On an octave change the new limit applies immediately: if counter ≥ new limit-1, the counter wraps and toggles next cycle.
- **Silence:** (code 0 or `enable` low) → `speaker`=0, counter=0, `note_active`=0, `note_code`=0.
- Debouncers keep running while `enable` is low, so the held state is correct when `enable` rises.

## Timing
- Reset values: `speaker`=0, `note_active`=0, `note_code`=0. All debounced states=0, counters=0.
- Latency from key edge: 2 sync cycles + DEBOUNCE_CYCLES → debounced edge; +1 → `note_code`/`note_active` registered; first `speaker` toggle after half_period further cycles.
- `enable` falling: outputs silent on the next clock edge. `enable` rising with a held key: tone starts on the next edge, counter from 0.
- Reset mid-note: immediate silence. A key still held after reset is re-accepted only after a full debounce.
- Arithmetic: period values are 32-bit unsigned. `MAP_W`>3 codes above 7 are treated as rest.

## Configuration
- `FREE_PLAY_SUSTAIN_EN` defined:
  - When the last key releases, the last code keeps sounding for SUSTAIN_CYCLES, then goes silent.
  - A new rising edge during sustain takes over immediately and cancels the tail.
  - `enable` low cancels the tail.
- `FREE_PLAY_SUSTAIN_EN` undefined: silence on the cycle after the release is registered. No sustain counter is built.

## Structure
- Package `free_play_pkg`:
  - Note-frequency table NOTE_MHZ in milli-Hz: 261626, 293665, 329628, 349228, 391995, 440000, 493883.
  - Function HALF_PERIOD(code, clk_hz) = clk_hz*500/NOTE_MHZ[code-1], using a 64-bit intermediate and rounding down; returns 0 for rest.
  - Code constants.
- Sub-module `key_debounce`: one sync + debounce channel, parameter DEBOUNCE_CYCLES, instantiated NUM_KEYS times.

## Test plan
All scenarios use CLK_HZ=1_000_000 and DEBOUNCE_CYCLES=4. Unless stated otherwise: key_map for key i = code i+1 (key 7 = code 0), octave 0, enable 1.
- Press key0 clean → `note_code`=1 at 2+4+1 cycles after the edge; `speaker` half-period = 1911 cycles.
- Key0 held, then key5 pressed → `note_code`=6 and half-period 1136. Release key5 → fallback to key0, code 1.
- Key2 bounces 1/0 every 2 cycles for 20 cycles → `note_code` never changes. Key2 then stable high → code 3 after 4 stable cycles.
- Key5 held, octave stepped 0→2 → half-period 1136→284. Key7 (code 0) held alone → `note_active`=0.
- Key0 held, `enable`=0 → `speaker`=0 next cycle. Assert `rst_n`=0 mid-tone → all outputs 0 asynchronously.
- With `FREE_PLAY_SUSTAIN_EN` and SUSTAIN_CYCLES=100: release key0 → tone continues for 100 cycles, then silent. Press key1 at cycle 50 of the tail → code 2 immediately.
